instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  - Fetch stage directly upstream of the instruction ROM: owns the PC, drives the ROM byte address, captures the returned word.
//  - Registers the fetched word into an IF/ID register with a valid bit for the decode stage.
//  - Supports stall (hold), redirect (branch/jal target, flushes IF/ID) and halt.
// PARAMETERS
//  ADDR_W    6            width of i_mem_addr (byte address; ROM decodes [ADDR_W-1:2])
//  RESET_PC  32'h0        PC value loaded on reset
//  TRAP_PC   32'h0000_0020  PC loaded on a misaligned redirect (MISALIGN_TRAP_EN only)
// PORTS
//  clk              in   1       rising-edge clock
//  rst_n            in   1       asynchronous, active-low reset
//  i_mem_addr       out  ADDR_W  byte address to instruction ROM = pc[ADDR_W-1:0], combinational
//  i_mem_data       in   32      instruction word from ROM, same cycle (combinational ROM)
//  stall            in   1       hold PC and IF/ID (decode back-pressure)
//  redirect         in   1       take redirect_target next edge; flush IF/ID
//  redirect_target  in   32      byte address of branch/jump target
//  halt             in   1       stop fetching until next redirect
//  if_id_instr      out  32      registered instruction
//  if_id_pc         out  32      byte PC of if_id_instr
//  if_id_pc_plus4   out  32      if_id_pc + 4 (jal link value)
//  if_id_valid      out  1       IF/ID holds a real instruction
//  fetch_count      out  32      number of valid IF/ID loads since reset
//  misalign         out  1       1-cycle pulse: misaligned redirect trapped
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc=RESET_PC, state=BOOT, if_id_instr=0, if_id_pc=0, if_id_pc_plus4=0, if_id_valid=0, fetch_count=0, misalign=0.
//  - States: BOOT -> RUN (unconditional, 1 cycle; pc held, valid=0, gives ROM one settled cycle).
//    RUN -> HALT when halt=1 and redirect=0. HALT -> RUN only on redirect=1. halt is ignored in BOOT.
//  - RUN priority per edge: redirect > stall > advance.
//    - redirect: pc<=redirect_target; if_id_valid<=0; other IF/ID fields hold.
//    - stall (no redirect): pc and all IF/ID fields hold; fetch_count holds.
//    - advance: if_id_instr<=i_mem_data, if_id_pc<=pc, if_id_pc_plus4<=pc+4, if_id_valid<=1, pc<=pc+4, fetch_count+=1.
//  - HALT: pc holds, if_id_valid<=0; redirect loads pc and moves to RUN (that edge loads no instruction).
//  - Redirect concurrent with stall: the redirect wins; the stalled instruction is dropped.
//  - Latency: instruction at pc appears on if_id_* one edge after pc is presented; the first valid word is 2 edges after rst_n rises.
//  - Arithmetic: 32-bit unsigned, pc+4 wraps 32'hFFFF_FFFC -> 32'h0; fetch_count wraps at 2^32.
//    i_mem_addr truncates pc (ROM aliases above 2^ADDR_W bytes); the block does not flag this.
//  - Reset asserted mid-operation clears everything immediately, regardless of clk.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: redirect with target[1:0]!=0 loads pc=TRAP_PC, flushes IF/ID and pulses misalign=1 on the following cycle.
//  MISALIGN_TRAP_EN undefined: the target's low 2 bits are forced to 0 (pc<={target[31:2],2'b00}); misalign is tied 0.
// TESTING
//  1 reset release, no stall: edge1 BOOT; edge2 if_id_pc=0, instr=ROM[0], valid=1; edge3 if_id_pc=4, if_id_pc_plus4=8; fetch_count=2.
//  2 stall=1 for 3 cycles with pc=8: i_mem_addr stays 8; if_id_* and fetch_count unchanged; the next advance loads if_id_pc=8.
//  3 redirect=1, target=0x24 with stall=1: next edge pc=0x24 and valid=0; the edge after that gives if_id_pc=0x24, instr=ROM[9].
//  4 halt=1 at pc=0x10: valid drops to 0 and pc holds 0x10 for 5 cycles; redirect target=0x28 -> RUN, then if_id_pc=0x28.
//  5 target=0x26: with MISALIGN_TRAP_EN, pc=0x20 and misalign pulses 1 cycle; without it, pc=0x24 and misalign=0.
//  6 rst_n low between edges mid-run: all outputs are reset values before the next edge; pc=RESET_PC; wrap check pc=FFFF_FFFC -> 0.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses the instruction ROM and registers the returned word into IF/ID.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned redirects to TRAP_PC instead of truncating).
module instruction_fetch #(
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0020
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] i_mem_addr,
    input  logic [31:0]       i_mem_data,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_target,
    input  logic              halt,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc,
    output logic [31:0]       if_id_pc_plus4,
    output logic              if_id_valid,
    output logic [31:0]       fetch_count,
    output logic              misalign
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_target;
    logic        target_trap;

    assign i_mem_addr = pc[ADDR_W-1:0];
    assign pc_plus4   = pc + 32'd4;

    // Resolve where a redirect actually lands, depending on the misalignment policy.
    always_comb begin
`ifdef MISALIGN_TRAP_EN
        target_trap = |redirect_target[1:0];
        next_target = target_trap ? TRAP_PC : redirect_target;
`else
        target_trap = 1'b0;
        next_target = redirect_target & 32'hFFFF_FFFC;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= BOOT;
            pc             <= RESET_PC;
            if_id_instr    <= 32'h0;
            if_id_pc       <= 32'h0;
            if_id_pc_plus4 <= 32'h0;
            if_id_valid    <= 1'b0;
            fetch_count    <= 32'h0;
            misalign       <= 1'b0;
        end else begin
            misalign <= 1'b0;
            case (state)
                // One settling cycle for the ROM; halt and redirect are not looked at here.
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (redirect) begin
                        pc          <= next_target;
                        if_id_valid <= 1'b0;
                        misalign    <= target_trap;
                    end else if (halt) begin
                        state       <= HALT;
                        if_id_valid <= 1'b0;
                    end else if (!stall) begin
                        if_id_instr    <= i_mem_data;
                        if_id_pc       <= pc;
                        if_id_pc_plus4 <= pc_plus4;
                        if_id_valid    <= 1'b1;
                        pc             <= pc_plus4;
                        fetch_count    <= fetch_count + 32'd1;
                    end
                end
                HALT: begin
                    if_id_valid <= 1'b0;
                    if (redirect) begin
                        pc       <= next_target;
                        misalign <= target_trap;
                        state    <= RUN;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch with a small combinational ROM model.
// Expectations for the misaligned redirect follow MISALIGN_TRAP_EN when it is defined.
module tb_instruction_fetch;

    localparam int ADDR_W = 6;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [31:0]       i_mem_data;
    logic              stall;
    logic              redirect;
    logic [31:0]       redirect_target;
    logic              halt;
    logic [31:0]       if_id_instr;
    logic [31:0]       if_id_pc;
    logic [31:0]       if_id_pc_plus4;
    logic              if_id_valid;
    logic [31:0]       fetch_count;
    logic              misalign;

    int checks;
    int failures;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic        halt;
        logic [31:0] target;
        logic [5:0]  exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_count;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    instruction_fetch #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(32'h0),
        .TRAP_PC (32'h0000_0020)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_mem_addr     (i_mem_addr),
        .i_mem_data     (i_mem_data),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .halt           (halt),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .fetch_count    (fetch_count),
        .misalign       (misalign)
    );

    function automatic logic [31:0] romWord(input logic [3:0] idx);
        return 32'hC0DE_0000 | {28'h0, idx};
    endfunction

    // 16-word ROM decoded from the byte address, so higher addresses alias.
    assign i_mem_data = romWord(i_mem_addr[5:2]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic addVec(input logic s, input logic r, input logic h, input logic [31:0] t,
                          input logic [5:0] a, input logic v, input logic [31:0] p,
                          input logic [31:0] c, input logic m);
        vec_t x;
        x.stall = s; x.redirect = r; x.halt = h; x.target = t;
        x.exp_addr = a; x.exp_valid = v; x.exp_pc = p; x.exp_count = c; x.exp_mis = m;
        vecs.push_back(x);
    endtask

    task automatic applyStimulus(input vec_t x);
        stall           = x.stall;
        redirect        = x.redirect;
        halt            = x.halt;
        redirect_target = x.target;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_addr"},   {26'h0, i_mem_addr}, 32'h0);
        checkOutput({tag, "_valid"},  {31'h0, if_id_valid}, 32'h0);
        checkOutput({tag, "_instr"},  if_id_instr, 32'h0);
        checkOutput({tag, "_pc"},     if_id_pc, 32'h0);
        checkOutput({tag, "_plus4"},  if_id_pc_plus4, 32'h0);
        checkOutput({tag, "_count"},  fetch_count, 32'h0);
        checkOutput({tag, "_mis"},    {31'h0, misalign}, 32'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        halt     = 1'b0;
        redirect_target = 32'h0;

        //     stall redir halt target        addr   valid if_id_pc      count mis
        addVec(0, 0, 0, 32'h0,         6'h00, 0, 32'h0,         0, 0); // BOOT
        addVec(0, 0, 0, 32'h0,         6'h04, 1, 32'h0,         1, 0);
        addVec(0, 0, 0, 32'h0,         6'h08, 1, 32'h4,         2, 0);
        addVec(1, 0, 0, 32'h0,         6'h08, 1, 32'h4,         2, 0); // stall x3
        addVec(1, 0, 0, 32'h0,         6'h08, 1, 32'h4,         2, 0);
        addVec(1, 0, 0, 32'h0,         6'h08, 1, 32'h4,         2, 0);
        addVec(0, 0, 0, 32'h0,         6'h0C, 1, 32'h8,         3, 0);
        addVec(0, 0, 0, 32'h0,         6'h10, 1, 32'hC,         4, 0);
        addVec(0, 0, 1, 32'h0,         6'h10, 0, 32'hC,         4, 0); // halt at 0x10
        addVec(0, 0, 1, 32'h0,         6'h10, 0, 32'hC,         4, 0);
        addVec(0, 0, 1, 32'h0,         6'h10, 0, 32'hC,         4, 0);
        addVec(0, 0, 0, 32'h0,         6'h10, 0, 32'hC,         4, 0);
        addVec(0, 0, 0, 32'h0,         6'h10, 0, 32'hC,         4, 0);
        addVec(0, 1, 0, 32'h28,        6'h28, 0, 32'hC,         4, 0); // leave HALT
        addVec(0, 0, 0, 32'h0,         6'h2C, 1, 32'h28,        5, 0);
        addVec(1, 1, 0, 32'h24,        6'h24, 0, 32'h28,        5, 0); // redirect beats stall
        addVec(0, 0, 0, 32'h0,         6'h28, 1, 32'h24,        6, 0);
`ifdef MISALIGN_TRAP_EN
        addVec(0, 1, 0, 32'h26,        6'h20, 0, 32'h24,        6, 1);
        addVec(0, 0, 0, 32'h0,         6'h24, 1, 32'h20,        7, 0);
        addVec(0, 1, 0, 32'hFFFF_FFFC, 6'h3C, 0, 32'h20,        7, 0);
`else
        addVec(0, 1, 0, 32'h26,        6'h24, 0, 32'h24,        6, 0);
        addVec(0, 0, 0, 32'h0,         6'h28, 1, 32'h24,        7, 0);
        addVec(0, 1, 0, 32'hFFFF_FFFC, 6'h3C, 0, 32'h24,        7, 0);
`endif
        addVec(0, 0, 0, 32'h0,         6'h00, 1, 32'hFFFF_FFFC, 8, 0); // pc wraps to 0

        #2;
        checkResetState("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_addr", i),  {26'h0, i_mem_addr}, {26'h0, vecs[i].exp_addr});
            checkOutput($sformatf("v%0d_valid", i), {31'h0, if_id_valid}, {31'h0, vecs[i].exp_valid});
            checkOutput($sformatf("v%0d_count", i), fetch_count, vecs[i].exp_count);
            checkOutput($sformatf("v%0d_mis", i),   {31'h0, misalign}, {31'h0, vecs[i].exp_mis});
            checkOutput($sformatf("v%0d_pc", i),    if_id_pc, vecs[i].exp_pc);
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("v%0d_instr", i), if_id_instr, romWord(vecs[i].exp_pc[5:2]));
                checkOutput($sformatf("v%0d_plus4", i), if_id_pc_plus4, vecs[i].exp_pc + 32'd4);
            end
        end

        // Asynchronous reset between edges, then halt held through BOOT.
        stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_target = 32'h0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkResetState("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        halt  = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("boot_valid", {31'h0, if_id_valid}, 32'h0);
        checkOutput("boot_addr", {26'h0, i_mem_addr}, 32'h0);
        halt = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("first_valid", {31'h0, if_id_valid}, 32'h1);
        checkOutput("first_pc", if_id_pc, 32'h0);
        checkOutput("first_instr", if_id_instr, romWord(4'd0));
        checkOutput("first_count", fetch_count, 32'h1);
        checkOutput("first_addr", {26'h0, i_mem_addr}, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
